bp_lce_lock_ctrl: RTL and testbench
===================================

BP_LCE_LOCK_CTRL -- requirements
Module: bp_lce_lock_ctrl

Interface
REQ-001 SHALL have parameter num_ports_p, default 3: number of LCE-to-cache memory ports monitored (tag, data, stat).
REQ-002 SHALL have parameter timeout_max_limit_p, default 4: consecutive blocked cycles before lock; legal range >= 1.
REQ-003 SHALL have parameter lock_hold_p, default 2: cycles the lock is held after all blocking clears; 0 disables HOLD.
REQ-004 SHALL have parameter credits_p, default 8: maximum outstanding cache requests.
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port reset_n_i, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pkt_v_i, input, num_ports_p: per-port LCE packet valid.
REQ-008 SHALL have port pkt_yumi_i, input, num_ports_p: per-port cache acceptance.
REQ-009 SHALL have port req_busy_i, input, 1: request engine busy.
REQ-010 SHALL have port cache_init_done_i, input, 1: cache initialisation complete.
REQ-011 SHALL have port credit_alloc_i, input, 1: one credit consumed (cache request accepted).
REQ-012 SHALL have port credit_return_i, input, 1: one credit returned.
REQ-013 SHALL have port cache_req_lock_o, output, 1: hint to the cache to withhold new requests.
REQ-014 SHALL have port timeout_o, output, num_ports_p: per-port counter at limit.
REQ-015 SHALL have port credit_count_o, output, clog2(credits_p+1): outstanding credits.
REQ-016 SHALL have port credits_full_o and credits_empty_o, outputs, 1 each.
REQ-017 SHALL have port credit_err_o, output, 1: sticky credit overflow/underflow flag.
REQ-018 SHALL have port lock_cycles_o, output, 16: count of locked cycles (see Configuration).

Function
REQ-019 SHALL compute blocked[p] = pkt_v_i[p] & ~pkt_yumi_i[p].
REQ-020 SHALL keep a per-port counter: increments on each blocked cycle, clears on any unblocked cycle, and saturates at timeout_max_limit_p.
REQ-021 SHALL assert timeout_o[p] iff counter[p] == timeout_max_limit_p.
REQ-022 SHALL implement FSM states IDLE, COUNT, LOCK, HOLD.
REQ-023 SHALL transition IDLE->COUNT when any port is blocked and no counter reaches the limit next cycle.
REQ-024 SHALL transition IDLE/COUNT->LOCK on the edge where any counter's next value equals the limit; with limit 1 this is the first blocked cycle.
REQ-025 SHALL transition COUNT->IDLE when no port is blocked.
REQ-026 SHALL remain in LOCK while any port is blocked, and leave LOCK to HOLD (lock_hold_p>0) or IDLE (lock_hold_p==0) when none is blocked.
REQ-027 SHALL count lock_hold_p cycles in HOLD then go to IDLE, and SHALL return to LOCK immediately if any port becomes blocked during HOLD.
REQ-028 SHALL drive cache_req_lock_o = (state in LOCK or HOLD) | req_busy_i | ~cache_init_done_i, combinationally from registered state.
REQ-029 SHALL update credit_count_o by +1 on alloc only, by -1 on return only, and leave it unchanged on simultaneous alloc and return.
REQ-030 SHALL hold credit_count_o and set credit_err_o on alloc-only at full or return-only at empty; credit_err_o stays set until reset.
REQ-031 SHALL drive credits_full_o = (count == credits_p) and credits_empty_o = (count == 0).

Reset
REQ-032 SHALL, on reset_n_i low and independent of clk_i, force: state IDLE, all port counters 0, timeout_o 0, hold counter 0, credit_count_o 0, credits_empty_o 1, credits_full_o 0, credit_err_o 0, lock_cycles_o 0.
REQ-033 SHALL, during reset, drive cache_req_lock_o from the req_busy_i and cache_init_done_i terms only.
REQ-034 SHALL abandon any in-progress LOCK or HOLD immediately on reset.
REQ-035 SHALL sample the first post-reset inputs on the first rising edge after reset_n_i deasserts.

Configuration
REQ-036 SHALL, with BP_LCE_LOCK_CTRL_STATS_EN defined, increment lock_cycles_o once per cycle in which state is LOCK or HOLD, saturating at 16'hFFFF.
REQ-037 SHALL, without BP_LCE_LOCK_CTRL_STATS_EN, tie lock_cycles_o to 0 and instantiate no statistics register.

Verification
REQ-038 Port 1 blocked 4 consecutive cycles (defaults) -> timeout_o=3'b010 and lock=1 from cycle 5; unblock -> lock stays 1 for 2 cycles, then 0.
REQ-039 Port 0 blocked 3 cycles, yumi on 4th, blocked again -> counter restarts; no lock until 4 more blocked cycles.
REQ-040 Reblock during HOLD cycle 1 -> immediate return to LOCK; lock never deasserts.
REQ-041 8 allocs -> full=1, count=8; 9th alloc -> count=8, credit_err_o=1; alloc+return together at count 5 -> count stays 5.
REQ-042 reset_n_i pulsed low mid-LOCK between clock edges -> lock drops (with req_busy_i=0, init_done=1), all counters 0 before the next edge.
REQ-043 STATS_EN defined, 10-cycle lock episode -> lock_cycles_o=10; macro undefined -> lock_cycles_o=0.

Source files
------------

// File: rtl/bp_lce_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bp_lce_lock_ctrl
// Description : Watches the LCE-to-cache memory ports for back-pressure and
//               raises a lock hint to the cache when any port stays blocked
//               for timeout_max_limit_p consecutive cycles. The lock is held
//               for lock_hold_p cycles after all blocking clears. Also tracks
//               outstanding cache-request credits with a sticky error flag.
//               Optional macro BP_LCE_LOCK_CTRL_STATS_EN enables a saturating
//               16-bit counter of cycles spent in LOCK/HOLD; without it,
//               lock_cycles_o is tied to zero and no register is built.
// Ports       : clk_i, reset_n_i (async, active-low)
//               pkt_v_i / pkt_yumi_i  - per-port packet valid / acceptance
//               req_busy_i, cache_init_done_i - extra lock terms
//               credit_alloc_i / credit_return_i - credit consume / return
//               cache_req_lock_o - withhold-new-requests hint
//               timeout_o        - per-port counter at limit
//               credit_count_o, credits_full_o, credits_empty_o, credit_err_o
//               lock_cycles_o    - locked-cycle statistic
// Revision    : 1.0 - initial release
// ============================================================================
module bp_lce_lock_ctrl #(
    parameter int num_ports_p         = 3,
    parameter int timeout_max_limit_p = 4,
    parameter int lock_hold_p         = 2,
    parameter int credits_p           = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_ports_p-1:0]             pkt_v_i,
    input  logic [num_ports_p-1:0]             pkt_yumi_i,
    input  logic                               req_busy_i,
    input  logic                               cache_init_done_i,
    input  logic                               credit_alloc_i,
    input  logic                               credit_return_i,
    output logic                               cache_req_lock_o,
    output logic [num_ports_p-1:0]             timeout_o,
    output logic [$clog2(credits_p+1)-1:0]     credit_count_o,
    output logic                               credits_full_o,
    output logic                               credits_empty_o,
    output logic                               credit_err_o,
    output logic [15:0]                        lock_cycles_o
);

    // Widths and constants
    localparam int TW          = $clog2(timeout_max_limit_p + 1);
    localparam int CW          = $clog2(credits_p + 1);
    localparam int HW          = (lock_hold_p > 1) ? $clog2(lock_hold_p) : 1;
    // HOLD is unreachable when lock_hold_p is 0; keep the constant legal anyway.
    localparam int HOLD_LAST_I = (lock_hold_p > 0) ? (lock_hold_p - 1) : 0;

    localparam logic [TW-1:0] LIMIT_C     = TW'(timeout_max_limit_p);
    localparam logic [HW-1:0] HOLD_LAST_C = HW'(HOLD_LAST_I);
    localparam logic [CW-1:0] CRED_MAX_C  = CW'(credits_p);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_LOCK  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic [CW-1:0]           cred_q, cred_d;
    logic                    err_q, err_d;
    logic [num_ports_p-1:0]  blocked;
    logic [num_ports_p-1:0]  hit_next;
    logic                    any_blocked;
    logic                    any_hit_next;
    logic                    locked_state;

    assign blocked      = pkt_v_i & ~pkt_yumi_i;
    assign any_blocked  = |blocked;
    assign any_hit_next = |hit_next;
    assign locked_state = (state_q == ST_LOCK) || (state_q == ST_HOLD);

    // ------------------------------------------------------------------------
    // Per-port consecutive-blocked counters (saturating at the limit)
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < num_ports_p; p++) begin : g_port
        logic [TW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = '0;
            if (blocked[p]) begin
                cnt_d = (cnt_q == LIMIT_C) ? cnt_q : cnt_q + TW'(1);
            end
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // Lock decisions look at the value the counter takes on this edge,
        // so the lock is visible in the same cycle the timeout appears.
        assign hit_next[p]  = (cnt_d == LIMIT_C);
        assign timeout_o[p] = (cnt_q == LIMIT_C);
    end

    // ------------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (any_hit_next) begin
                    state_d = ST_LOCK;
                end else if (any_blocked) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (any_hit_next) begin
                    state_d = ST_LOCK;
                end else if (!any_blocked) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (!any_blocked) begin
                    hold_d  = '0;
                    state_d = (lock_hold_p > 0) ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (any_blocked) begin
                    // Re-blocking during the hold window re-locks at once.
                    hold_d  = '0;
                    state_d = ST_LOCK;
                end else if (hold_q == HOLD_LAST_C) begin
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                hold_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset forces state_q to IDLE asynchronously, so during reset only the
    // busy/init terms can hold the lock.
    assign cache_req_lock_o = locked_state | req_busy_i | ~cache_init_done_i;

    // ------------------------------------------------------------------------
    // Credit tracking
    // ------------------------------------------------------------------------
    always_comb begin
        cred_d = cred_q;
        err_d  = err_q;
        if (credit_alloc_i && !credit_return_i) begin
            if (cred_q == CRED_MAX_C) begin
                err_d = 1'b1;
            end else begin
                cred_d = cred_q + CW'(1);
            end
        end else if (credit_return_i && !credit_alloc_i) begin
            if (cred_q == '0) begin
                err_d = 1'b1;
            end else begin
                cred_d = cred_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cred_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cred_q <= cred_d;
            err_q  <= err_d;
        end
    end

    assign credit_count_o  = cred_q;
    assign credits_full_o  = (cred_q == CRED_MAX_C);
    assign credits_empty_o = (cred_q == '0);
    assign credit_err_o    = err_q;

    // ------------------------------------------------------------------------
    // Optional locked-cycle statistic
    // ------------------------------------------------------------------------
`ifdef BP_LCE_LOCK_CTRL_STATS_EN
    logic [15:0] stats_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stats_q <= '0;
        end else if (locked_state && (stats_q != 16'hFFFF)) begin
            stats_q <= stats_q + 16'd1;
        end
    end

    assign lock_cycles_o = stats_q;
`else
    assign lock_cycles_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_lce_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_lce_lock_ctrl
// Description : Scoreboard bench for bp_lce_lock_ctrl. A driver applies
//               directed and random stimulus on the falling edge, steps a
//               behavioural model and queues the expected outputs; a monitor
//               pops and compares one entry after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_lce_lock_ctrl;

    localparam int NP = 3;
    localparam int L  = 4;
    localparam int H  = 2;
    localparam int CR = 8;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [NP-1:0] pkt_v_i, pkt_yumi_i;
    logic          req_busy_i, cache_init_done_i;
    logic          credit_alloc_i, credit_return_i;
    logic          cache_req_lock_o;
    logic [NP-1:0] timeout_o;
    logic [3:0]    credit_count_o;
    logic          credits_full_o, credits_empty_o, credit_err_o;
    logic [15:0]   lock_cycles_o;

    bp_lce_lock_ctrl #(
        .num_ports_p         (NP),
        .timeout_max_limit_p (L),
        .lock_hold_p         (H),
        .credits_p           (CR)
    ) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .pkt_v_i           (pkt_v_i),
        .pkt_yumi_i        (pkt_yumi_i),
        .req_busy_i        (req_busy_i),
        .cache_init_done_i (cache_init_done_i),
        .credit_alloc_i    (credit_alloc_i),
        .credit_return_i   (credit_return_i),
        .cache_req_lock_o  (cache_req_lock_o),
        .timeout_o         (timeout_o),
        .credit_count_o    (credit_count_o),
        .credits_full_o    (credits_full_o),
        .credits_empty_o   (credits_empty_o),
        .credit_err_o      (credit_err_o),
        .lock_cycles_o     (lock_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NP-1:0] to;
        logic          lock;
        logic [3:0]    cnt;
        logic          full;
        logic          empty;
        logic          err;
        logic [15:0]   lc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model: run lengths per port, a "locked" flag and a count of
    // hold cycles still to serve once blocking has cleared.
    int run [NP];
    bit m_locked;
    int m_hold_left;
    int m_cred;
    bit m_err;
    int m_stats;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) run[p] = 0;
        m_locked    = 1'b0;
        m_hold_left = 0;
        m_cred      = 0;
        m_err       = 1'b0;
        m_stats     = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven and
    // queue what the DUT should show after the coming rising edge.
    task automatic push_cycle();
        bit   any_blk, any_hit, was_locked;
        exp_t e;
        any_blk    = 1'b0;
        any_hit    = 1'b0;
        was_locked = m_locked || (m_hold_left > 0);
        for (int p = 0; p < NP; p++) begin
            if (pkt_v_i[p] && !pkt_yumi_i[p]) begin
                any_blk = 1'b1;
                run[p]  = (run[p] + 1 > L) ? L : run[p] + 1;
            end else begin
                run[p] = 0;
            end
            if (run[p] == L) any_hit = 1'b1;
        end
        if (m_locked) begin
            if (!any_blk) begin
                m_locked    = 1'b0;
                m_hold_left = H;
            end
        end else if (m_hold_left > 0) begin
            if (any_blk) begin
                m_locked    = 1'b1;
                m_hold_left = 0;
            end else begin
                m_hold_left--;
            end
        end else if (any_hit) begin
            m_locked = 1'b1;
        end
        if (credit_alloc_i && !credit_return_i) begin
            if (m_cred == CR) m_err = 1'b1; else m_cred++;
        end else if (credit_return_i && !credit_alloc_i) begin
            if (m_cred == 0) m_err = 1'b1; else m_cred--;
        end
        if (was_locked && m_stats < 16'hFFFF) m_stats++;

        for (int p = 0; p < NP; p++) e.to[p] = (run[p] == L);
        e.lock  = m_locked || (m_hold_left > 0) || req_busy_i || !cache_init_done_i;
        e.cnt   = 4'(m_cred);
        e.full  = (m_cred == CR);
        e.empty = (m_cred == 0);
        e.err   = m_err;
`ifdef BP_LCE_LOCK_CTRL_STATS_EN
        e.lc    = 16'(m_stats);
`else
        e.lc    = 16'h0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [NP-1:0] v, input logic [NP-1:0] y,
                        input logic busy, input logic init,
                        input logic al, input logic rt);
        @(negedge clk_i);
        pkt_v_i           = v;
        pkt_yumi_i        = y;
        req_busy_i        = busy;
        cache_init_done_i = init;
        credit_alloc_i    = al;
        credit_return_i   = rt;
        push_cycle();
    endtask

    task automatic blk(input logic [NP-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(v, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Reset pulse between clock edges; the outputs must clear before any
    // edge arrives, and the edge after release samples the driven inputs.
    task automatic reset_mid(input logic [NP-1:0] v);
        @(negedge clk_i);
        pkt_v_i           = v;
        pkt_yumi_i        = '0;
        req_busy_i        = 1'b0;
        cache_init_done_i = 1'b1;
        credit_alloc_i    = 1'b0;
        credit_return_i   = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        chk("rst_lock",    32'(cache_req_lock_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o),        32'd0);
        chk("rst_count",   32'(credit_count_o),   32'd0);
        chk("rst_empty",   32'(credits_empty_o),  32'd1);
        chk("rst_full",    32'(credits_full_o),   32'd0);
        chk("rst_err",     32'(credit_err_o),     32'd0);
        chk("rst_lcycles", 32'(lock_cycles_o),    32'd0);
        model_reset();
        #1 reset_n_i = 1'b1;
        push_cycle();
    endtask

    // Monitor: one queued expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("timeout_o",    32'(timeout_o),        32'(e.to));
                chk("lock_o",       32'(cache_req_lock_o), 32'(e.lock));
                chk("credit_count", 32'(credit_count_o),   32'(e.cnt));
                chk("credits_full", 32'(credits_full_o),   32'(e.full));
                chk("credits_empty",32'(credits_empty_o),  32'(e.empty));
                chk("credit_err",   32'(credit_err_o),     32'(e.err));
                chk("lock_cycles",  32'(lock_cycles_o),    32'(e.lc));
            end
        end
    end

    initial begin
        logic [NP-1:0] v, y;
        logic          heavy;
        reset_n_i         = 1'b0;
        pkt_v_i           = '0;
        pkt_yumi_i        = '0;
        req_busy_i        = 1'b0;
        cache_init_done_i = 1'b1;
        credit_alloc_i    = 1'b0;
        credit_return_i   = 1'b0;
        model_reset();
        heavy = 1'b0;

        // Reset state, including the init/busy terms of the lock.
        #3;
        chk("init_lock",    32'(cache_req_lock_o), 32'd0);
        chk("init_timeout", 32'(timeout_o),        32'd0);
        chk("init_empty",   32'(credits_empty_o),  32'd1);
        chk("init_count",   32'(credit_count_o),   32'd0);
        cache_init_done_i = 1'b0;
        #1 chk("init_lock_noinit", 32'(cache_req_lock_o), 32'd1);
        cache_init_done_i = 1'b1;
        req_busy_i        = 1'b1;
        #1 chk("init_lock_busy", 32'(cache_req_lock_o), 32'd1);
        req_busy_i        = 1'b0;

        @(negedge clk_i);
        reset_n_i = 1'b1;
        push_cycle();

        // Port 1 blocked four cycles, then released through the hold window.
        blk(3'b010, 4);
        blk(3'b000, 4);
        // Port 0 blocked three cycles, accepted, then blocked again.
        blk(3'b001, 3);
        step(3'b001, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        blk(3'b001, 4);
        blk(3'b000, 4);
        // Re-block on the first hold cycle.
        blk(3'b100, 4);
        blk(3'b000, 1);
        blk(3'b100, 2);
        blk(3'b000, 4);
        // Credits: fill, overflow, drain to 5, simultaneous alloc/return.
        for (int i = 0; i < 9; i++) step('0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step('0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        // Ten-cycle lock episode (8 locked + 2 hold).
        blk(3'b010, 11);
        blk(3'b000, 4);
        // Reset mid-LOCK.
        blk(3'b110, 6);
        reset_mid(3'b010);
        blk(3'b000, 3);

        // Randomised traffic in segments of light and heavy back-pressure.
        for (int i = 0; i < 3000; i++) begin
            if (i % 16 == 0) heavy = ($urandom_range(0, 3) != 0);
            v = 3'($urandom);
            y = heavy ? 3'($urandom & $urandom & $urandom) : 3'($urandom);
            if (heavy && $urandom_range(0, 7) == 0) y = 3'b111;
            if ($urandom_range(0, 399) == 0) begin
                reset_mid(v);
            end else begin
                step(v, y, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) != 0),
                     1'($urandom), 1'($urandom));
            end
        end

        step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk_i);
        #2;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
